// File: rtl/hex_display_ctrl_if.sv
// Load handshake between the SoC PIO exports and the display controller.
// The master drives a value/format request; the slave reports when it can take one.
interface hex_display_ctrl_if #(
    parameter int unsigned VAL_W = 16
);
    logic             load;
    logic [VAL_W-1:0] value;
    logic [1:0]       mode;
    logic             blank_lz;
    logic             ready;

    modport master (output load, value, mode, blank_lz, input ready);
    modport slave  (input load, value, mode, blank_lz, output ready);
endinterface

// File: rtl/hex_display_ctrl.sv
// N-digit active-low 7-segment controller: hex / unsigned / signed decimal rendering via an
// iterative double-dabble, with leading-zero blanking, overflow flag and per-digit blinking.
module hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned VAL_W      = 16,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                    MAX10_CLK1_50,
    input  logic                    Reset_h,
    hex_display_ctrl_if.slave       host,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic                    overflow,
    output logic [NUM_DIGITS*8-1:0] seg
);
    // Decimal digits of 2^VAL_W-1 is floor(VAL_W*log10(2))+1.
    localparam int unsigned BCD_DIGITS = (VAL_W * 30103) / 100000 + 1;
    localparam int unsigned NIBBLES    = (VAL_W + 3) / 4;
    localparam int unsigned MAX_ND     = (NUM_DIGITS > NIBBLES) ? NUM_DIGITS : NIBBLES;
    localparam int unsigned SRC_DIGITS = (MAX_ND > BCD_DIGITS) ? MAX_ND : BCD_DIGITS;
    localparam int unsigned CNT_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned STEP_W     = $clog2(VAL_W + 1);

    typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

    state_e                  state_q;
    logic [VAL_W-1:0]        mag_q;
    logic [4*BCD_DIGITS-1:0] bcd_q;
    logic [1:0]              mode_q;
    logic                    blank_q;
    logic                    neg_q;
    logic [STEP_W-1:0]       step_q;
    logic                    ready_q;
    logic                    overflow_q;
    logic [NUM_DIGITS*8-1:0] frame_q;
    logic [CNT_W-1:0]        blink_cnt_q;
    logic                    phase_q;

    logic [4*BCD_DIGITS-1:0] bcd_adj;
    logic [4*BCD_DIGITS-1:0] bcd_next;
    logic [4*SRC_DIGITS-1:0] src_vec;
    logic [NUM_DIGITS*8-1:0] frame_d;
    logic                    overflow_d;
    logic                    accept_neg;
    int                      nsig;
    int                      need;
    int                      sign_pos;

    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign accept_neg = (host.mode == 2'b10) && host.value[VAL_W-1];

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next magnitude bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        bcd_next = (bcd_adj << 1) | (4*BCD_DIGITS)'(mag_q[VAL_W-1]);
    end

    always_comb begin
        src_vec = (mode_q == 2'b00) ? (4*SRC_DIGITS)'(mag_q) : (4*SRC_DIGITS)'(bcd_q);
        nsig = 1;
        for (int k = 0; k < SRC_DIGITS; k++) begin
            if (src_vec[4*k +: 4] != 4'd0) nsig = k + 1;
        end
        need       = nsig + (neg_q ? 1 : 0);
        sign_pos   = blank_q ? nsig : int'(NUM_DIGITS) - 1;
        frame_d    = '1;
        overflow_d = 1'b0;
        if (mode_q != 2'b11) begin
            if (need > int'(NUM_DIGITS) && mode_q != 2'b00) begin
                overflow_d = 1'b1;
                frame_d    = {NUM_DIGITS{8'hBF}};
            end else begin
                // Hex overflow still shows the low nibbles; only decimal is replaced by dashes.
                overflow_d = need > int'(NUM_DIGITS);
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (neg_q && i == sign_pos) frame_d[8*i +: 8] = 8'hBF;
                    else if (blank_q && i >= nsig) frame_d[8*i +: 8] = 8'hFF;
                    else frame_d[8*i +: 8] = seg_enc(src_vec[4*i +: 4]);
                end
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (Reset_h) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            bcd_q       <= '0;
            mode_q      <= 2'b11;
            blank_q     <= 1'b0;
            neg_q       <= 1'b0;
            step_q      <= '0;
            ready_q     <= 1'b1;
            overflow_q  <= 1'b0;
            frame_q     <= '1;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + CNT_W'(1);
            end

            case (state_q)
                StIdle: begin
                    if (host.load && ready_q) begin
                        // VAL_W-bit negation equals the VAL_W+1-bit result read as unsigned,
                        // so the most negative input yields 2^(VAL_W-1).
                        mag_q   <= accept_neg ? (~host.value + VAL_W'(1)) : host.value;
                        neg_q   <= accept_neg;
                        mode_q  <= host.mode;
                        blank_q <= host.blank_lz;
                        bcd_q   <= '0;
                        step_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    if (mode_q == 2'b01 || mode_q == 2'b10) begin
                        bcd_q  <= bcd_next;
                        mag_q  <= mag_q << 1;
                        step_q <= step_q + STEP_W'(1);
                        if (step_q == STEP_W'(VAL_W - 1)) state_q <= StCommit;
                    end else begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    frame_q    <= frame_d;
                    overflow_q <= overflow_d;
                    ready_q    <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg[8*i +: 8] = (blink_en[i] && phase_q) ? 8'hFF : frame_q[8*i +: 8];
        end
    end

    assign host.ready = ready_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: a 6-digit and a 4-digit instance, expected frames
// come from hand-derived constants or an arithmetic reference model.
module tb_hex_display_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  blink6;
    logic [3:0]  blink4;
    logic        ovf6, ovf4;
    logic [47:0] seg6;
    logic [31:0] seg4;
    logic [47:0] last6;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [47:0] frame;
        logic        ovf;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    hex_display_ctrl_if #(.VAL_W(16)) bus6 ();
    hex_display_ctrl_if #(.VAL_W(16)) bus4 ();

    hex_display_ctrl #(.NUM_DIGITS(6), .VAL_W(16), .BLINK_DIV(4)) dut6 (
        .MAX10_CLK1_50(clk), .Reset_h(rst), .host(bus6), .blink_en(blink6),
        .overflow(ovf6), .seg(seg6)
    );
    hex_display_ctrl #(.NUM_DIGITS(4), .VAL_W(16), .BLINK_DIV(4)) dut4 (
        .MAX10_CLK1_50(clk), .Reset_h(rst), .host(bus4), .blink_en(blink4),
        .overflow(ovf4), .seg(seg4)
    );

    // Reference: digits by repeated division, frame padded with FF above nd digits.
    function automatic void model(input int nd, input logic [15:0] v, input logic [1:0] m,
                                  input logic blz, output logic [47:0] fr, output logic ov);
        int mag, nsig, neg, pos;
        int dig[8];
        fr = '1;
        ov = 1'b0;
        if (m == 2'b11) return;
        neg = (m == 2'b10 && v[15]) ? 1 : 0;
        mag = int'(v);
        if (neg == 1) mag = 65536 - mag;
        for (int k = 0; k < 8; k++) begin
            if (m == 2'b00) dig[k] = (mag >> (4 * k)) & 15;
            else begin
                dig[k] = mag % 10;
                mag = mag / 10;
            end
        end
        nsig = 1;
        for (int k = 0; k < 8; k++) if (dig[k] != 0) nsig = k + 1;
        if (m != 2'b00 && nsig + neg > nd) begin
            ov = 1'b1;
            for (int i = 0; i < nd; i++) fr[8*i +: 8] = 8'hBF;
            return;
        end
        ov = (nsig > nd);
        for (int i = 0; i < nd; i++) fr[8*i +: 8] = (blz && i >= nsig) ? 8'hFF : lut[dig[i]];
        if (neg == 1) begin
            pos = blz ? nsig : nd - 1;
            fr[8*pos +: 8] = 8'hBF;
        end
    endfunction

    task automatic drive(input bit use4, input logic [15:0] v, input logic [1:0] m,
                         input logic blz, input logic [47:0] fr, input logic ov);
        exp_t e;
        @(negedge clk);
        if (use4) begin
            bus4.load = 1'b1; bus4.value = v; bus4.mode = m; bus4.blank_lz = blz;
        end else begin
            bus6.load = 1'b1; bus6.value = v; bus6.mode = m; bus6.blank_lz = blz;
        end
        @(posedge clk);
        #1;
        bus4.load = 1'b0;
        bus6.load = 1'b0;
        e.frame = fr;
        e.ovf   = ov;
        e.lat   = (m == 2'b01 || m == 2'b10) ? 17 : 2;
        sb.push_back(e);
    endtask

    task automatic await_ready(input bit use4, output int lat, output bit to);
        to  = 1'b1;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if ((use4 ? bus4.ready : bus6.ready) == 1'b1) begin
                lat = n;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus6.load = 1'b1; bus6.value = 16'h1234; bus6.mode = 2'b00; bus6.blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (seg6 !== 48'hFFFF_FFFF_FFFF) begin n_bad++; $display("FAIL reset_seg6: got %h want %h", seg6, 48'hFFFF_FFFF_FFFF); end
        n_cmp++; if (bus6.ready !== 1'b1 || ovf6 !== 1'b0) begin n_bad++; $display("FAIL reset_flags6: got ready=%b ovf=%b want 1 0", bus6.ready, ovf6); end
        n_cmp++; if (seg4 !== 32'hFFFF_FFFF || bus4.ready !== 1'b1 || ovf4 !== 1'b0) begin n_bad++; $display("FAIL reset_dut4: got seg=%h ready=%b ovf=%b want ffffffff 1 0", seg4, bus4.ready, ovf4); end
        rst = 1'b0;
        bus6.load = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus6.ready !== 1'b1 || seg6 !== 48'hFFFF_FFFF_FFFF) begin n_bad++; $display("FAIL reset_load_ignored: got ready=%b seg=%h want 1 ffffffffffff", bus6.ready, seg6); end
        last6 = 48'hFFFF_FFFF_FFFF;
    endtask

    task automatic test_hex();
        logic [15:0] vals [4] = '{16'h1A3F, 16'h00A0, 16'h0000, 16'h1234};
        logic [1:0]  mods [4] = '{2'b00, 2'b00, 2'b00, 2'b11};
        logic        blzs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [47:0] frs  [4] = '{48'hC0C0_F988_B08E, 48'hFFFF_FFFF_88C0,
                                  48'hFFFF_FFFF_FFC0, 48'hFFFF_FFFF_FFFF};
        exp_t e;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, vals[i], mods[i], blzs[i], frs[i], 1'b0);
            await_ready(1'b0, lat, to);
            e = sb.pop_front();
            n_cmp++; if (to) begin n_bad++; $display("FAIL hex_timeout[%0d]: got no ready want ready within 40", i); end
            n_cmp++; if (seg6 !== e.frame) begin n_bad++; $display("FAIL hex_seg[%0d]: got %h want %h", i, seg6, e.frame); end
            n_cmp++; if (ovf6 !== e.ovf || lat != e.lat) begin n_bad++; $display("FAIL hex_ovf_lat[%0d]: got ovf=%b lat=%0d want %b %0d", i, ovf6, lat, e.ovf, e.lat); end
            last6 = e.frame;
        end
    endtask

    task automatic test_decimal();
        exp_t e;
        int lat = 0;
        drive(1'b0, 16'hFFFF, 2'b01, 1'b1, 48'hFF82_9292_B092, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                n_cmp++; if (seg6 !== last6) begin n_bad++; $display("FAIL dec_hold: got %h want %h", seg6, last6); end
            end
            if (n == 16) begin
                n_cmp++; if (bus6.ready !== 1'b0) begin n_bad++; $display("FAIL dec_busy16: got ready=%b want 0", bus6.ready); end
            end
            if (n == 5) begin
                bus6.load = 1'b1; bus6.value = 16'h0001; bus6.mode = 2'b00;
            end
            if (n == 6) bus6.load = 1'b0;
            if (bus6.ready == 1'b1) begin
                lat = n;
                break;
            end
        end
        e = sb.pop_front();
        n_cmp++; if (lat != e.lat) begin n_bad++; $display("FAIL dec_latency: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (seg6 !== e.frame || ovf6 !== e.ovf) begin n_bad++; $display("FAIL dec_seg: got %h ovf=%b want %h %b", seg6, ovf6, e.frame, e.ovf); end
        repeat (3) @(negedge clk);
        n_cmp++; if (bus6.ready !== 1'b1 || seg6 !== e.frame) begin n_bad++; $display("FAIL dec_ignored_load: got ready=%b seg=%h want 1 %h", bus6.ready, seg6, e.frame); end
        last6 = e.frame;
    endtask

    task automatic test_signed();
        logic [15:0] vals [4] = '{16'h8000, 16'hFFFF, 16'hFFFB, 16'h0064};
        logic        blzs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [47:0] frs  [4] = '{48'hBFB0_A4F8_8280, 48'hFFFF_FFFF_BFF9,
                                  48'hBFC0_C0C0_C092, 48'hFFFF_FFF9_C0C0};
        exp_t e;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, vals[i], 2'b10, blzs[i], frs[i], 1'b0);
            await_ready(1'b0, lat, to);
            e = sb.pop_front();
            n_cmp++; if (to || lat != e.lat) begin n_bad++; $display("FAIL signed_lat[%0d]: got lat=%0d timeout=%b want %0d", i, lat, to, e.lat); end
            n_cmp++; if (seg6 !== e.frame || ovf6 !== e.ovf) begin n_bad++; $display("FAIL signed_seg[%0d]: got %h ovf=%b want %h %b", i, seg6, ovf6, e.frame, e.ovf); end
            last6 = e.frame;
        end
    endtask

    task automatic test_narrow();
        logic [15:0] vals [4] = '{16'd12345, 16'h1234, 16'hFC19, 16'hFC18};
        logic [1:0]  mods [4] = '{2'b01, 2'b00, 2'b10, 2'b10};
        logic        blzs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [47:0] fr;
        logic        ov;
        exp_t e;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin fr = 48'hFFFF_BFBF_BFBF; ov = 1'b1; end
            else if (i == 1) begin fr = 48'hFFFF_F9A4_B099; ov = 1'b0; end
            else model(4, vals[i], mods[i], blzs[i], fr, ov);
            drive(1'b1, vals[i], mods[i], blzs[i], fr, ov);
            await_ready(1'b1, lat, to);
            e = sb.pop_front();
            n_cmp++; if (to || lat != e.lat) begin n_bad++; $display("FAIL narrow_lat[%0d]: got lat=%0d timeout=%b want %0d", i, lat, to, e.lat); end
            n_cmp++; if (seg4 !== e.frame[31:0] || ovf4 !== e.ovf) begin n_bad++; $display("FAIL narrow_seg[%0d]: got %h ovf=%b want %h %b", i, seg4, ovf4, e.frame[31:0], e.ovf); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic [1:0]  m;
        logic        blz;
        logic [47:0] fr;
        logic        ov;
        exp_t e;
        int lat;
        bit to;
        for (int i = 0; i < 12; i++) begin
            v   = 16'($urandom);
            m   = 2'($urandom_range(0, 3));
            blz = 1'($urandom_range(0, 1));
            if (i % 3 == 0) v = v >> $urandom_range(4, 14);
            model(6, v, m, blz, fr, ov);
            drive(1'b0, v, m, blz, fr, ov);
            await_ready(1'b0, lat, to);
            e = sb.pop_front();
            n_cmp++; if (to || lat != e.lat) begin n_bad++; $display("FAIL b2b_lat[%0d]: got lat=%0d timeout=%b want %0d", i, lat, to, e.lat); end
            n_cmp++; if (seg6 !== e.frame || ovf6 !== e.ovf) begin n_bad++; $display("FAIL b2b_seg[%0d] v=%h m=%0d blz=%b: got %h ovf=%b want %h %b", i, v, m, blz, seg6, ovf6, e.frame, e.ovf); end
            last6 = e.frame;
        end
    endtask

    task automatic test_blink();
        logic [7:0] want;
        @(negedge clk);
        rst = 1'b1;
        blink6 = 6'b000001;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus6.load = 1'b1; bus6.value = 16'h0000; bus6.mode = 2'b00; bus6.blank_lz = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            if (c == 1) begin
                #1;
                bus6.load = 1'b0;
            end
            @(negedge clk);
            if (c == 3) begin
                n_cmp++; if (seg6[47:8] !== 40'hFF_FFFF_FFFF) begin n_bad++; $display("FAIL blink_upper: got %h want ffffffffff", seg6[47:8]); end
            end
            if (c >= 3) begin
                want = (((c / 4) % 2) == 1) ? 8'hFF : 8'hC0;
                n_cmp++; if (seg6[7:0] !== want) begin n_bad++; $display("FAIL blink_digit0[c=%0d]: got %h want %h", c, seg6[7:0], want); end
            end
        end
        blink6 = 6'b000000;
        #1;
        n_cmp++; if (seg6 !== 48'hFFFF_FFFF_FFC0) begin n_bad++; $display("FAIL blink_off: got %h want ffffffffffc0", seg6); end
        last6 = 48'hFFFF_FFFF_FFC0;
    endtask

    task automatic test_reset_abort();
        logic [47:0] fr;
        logic        ov;
        exp_t e;
        int lat;
        bit to;
        @(negedge clk);
        bus6.load = 1'b1; bus6.value = 16'd12345; bus6.mode = 2'b01; bus6.blank_lz = 1'b0;
        @(posedge clk);
        #1;
        bus6.load = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (seg6 !== 48'hFFFF_FFFF_FFFF || bus6.ready !== 1'b1 || ovf6 !== 1'b0) begin n_bad++; $display("FAIL abort_reset: got seg=%h ready=%b ovf=%b want ffffffffffff 1 0", seg6, bus6.ready, ovf6); end
        repeat (25) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (seg6 !== 48'hFFFF_FFFF_FFFF || bus6.ready !== 1'b1) begin n_bad++; $display("FAIL abort_no_commit: got seg=%h ready=%b want ffffffffffff 1", seg6, bus6.ready); end
        model(6, 16'h0007, 2'b00, 1'b1, fr, ov);
        drive(1'b0, 16'h0007, 2'b00, 1'b1, fr, ov);
        await_ready(1'b0, lat, to);
        e = sb.pop_front();
        n_cmp++; if (to || seg6 !== e.frame || lat != e.lat) begin n_bad++; $display("FAIL abort_recover: got seg=%h lat=%0d want %h %0d", seg6, lat, e.frame, e.lat); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
    endtask

    initial begin
        rst = 1'b1;
        blink6 = '0;
        blink4 = '0;
        bus6.load = 1'b0; bus6.value = '0; bus6.mode = 2'b00; bus6.blank_lz = 1'b0;
        bus4.load = 1'b0; bus4.value = '0; bus4.mode = 2'b00; bus4.blank_lz = 1'b0;
        test_reset();
        test_hex();
        test_decimal();
        test_signed();
        test_narrow();
        test_back_to_back();
        test_blink();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
